// File: rtl/di_pkg.sv
// Shared definitions for the device-interface register terminal:
// status bit positions, FSM state encoding and the out-of-range filler word.
package di_pkg;

    localparam int DI_STAT_ADDR_RANGE = 0;
    localparam int DI_STAT_RO_WRITE   = 1;
    localparam int DI_STAT_TERM_MISS  = 2;

    localparam logic [31:0] DI_FILLER = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        VALID  = 2'd2,
        COMMIT = 2'd3
    } di_state_e;

endpackage

// File: rtl/di_reg_terminal_stats.sv
// Saturating access counters for the register terminal: committed writes
// and consumed reads, exposed as two extra read-only words.
module di_reg_terminal_stats (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_inc,
    input  logic        rd_inc,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= 32'd0;
            rd_cnt <= 32'd0;
        end else begin
            if (wr_inc && (wr_cnt != 32'hFFFF_FFFF))
                wr_cnt <= wr_cnt + 32'd1;
            if (rd_inc && (rd_cnt != 32'hFFFF_FFFF))
                rd_cnt <= rd_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/di_reg_terminal.sv
// Register-bank terminal on the di_* bus: decodes terminal/register address,
// commits writes, prefetches read data. Optional DI_REG_TERMINAL_STATS_EN adds counters.
module di_reg_terminal
    import di_pkg::*;
#(
    parameter logic [15:0]         TERM_ADDR   = 16'h0050,
    parameter int                  NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK     = {NUM_REGS{1'b0}},
    parameter logic [31:0]         RESET_VALUE = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [15:0]              di_term_addr,
    input  logic [31:0]              di_reg_addr,
    input  logic                     di_read_mode,
    input  logic                     di_read_req,
    input  logic                     di_read,
    output logic                     di_read_rdy,
    output logic [31:0]              di_reg_datao,
    input  logic                     di_write_mode,
    input  logic                     di_write,
    output logic                     di_write_rdy,
    input  logic [31:0]              di_reg_datai,
    output logic [15:0]              di_transfer_status,
    output logic [32*NUM_REGS-1:0]   reg_q,
    input  logic [32*NUM_REGS-1:0]   ro_d,
    output logic [NUM_REGS-1:0]      wr_strobe
);

`ifdef DI_REG_TERMINAL_STATS_EN
    localparam int LIMIT = NUM_REGS + 2;
`else
    localparam int LIMIT = NUM_REGS;
`endif

    di_state_e   state, state_nxt;
    logic [31:0] fetch_addr;
    logic        wr_acc, wr_legal, rd_evt;
    logic        addr_bad, ro_hit, term_miss;
    logic [15:0] stat_new;
    logic [31:0] rd_word;

`ifdef DI_REG_TERMINAL_STATS_EN
    logic [31:0] stat_wr_cnt, stat_rd_cnt;

    di_reg_terminal_stats u_stats (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_inc  (wr_legal),
        .rd_inc  (di_read && !wr_acc),
        .wr_cnt  (stat_wr_cnt),
        .rd_cnt  (stat_rd_cnt)
    );
`endif

    // Address decode and access classification
    always_comb begin
        addr_bad  = (di_reg_addr >= 32'(LIMIT));
        term_miss = (di_term_addr != TERM_ADDR);
        ro_hit    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (RO_MASK[i] && (di_reg_addr == 32'(i)))
                ro_hit = 1'b1;
`ifdef DI_REG_TERMINAL_STATS_EN
        if ((di_reg_addr == 32'(NUM_REGS)) || (di_reg_addr == 32'(NUM_REGS + 1)))
            ro_hit = 1'b1;
`endif
        // A write during COMMIT is ignored; a write beats a simultaneous read.
        wr_acc   = di_write && (state != COMMIT);
        wr_legal = wr_acc && !addr_bad && !ro_hit && !term_miss;
        rd_evt   = di_read_req || (di_read && !wr_acc);

        stat_new                     = 16'h0000;
        stat_new[DI_STAT_ADDR_RANGE] = addr_bad && (rd_evt || wr_acc);
        stat_new[DI_STAT_RO_WRITE]   = wr_acc && ro_hit;
        stat_new[DI_STAT_TERM_MISS]  = term_miss && (di_read_req || wr_acc);
    end

    always_comb begin
        rd_word = DI_FILLER;
        for (int i = 0; i < NUM_REGS; i++)
            if (di_reg_addr == 32'(i))
                rd_word = RO_MASK[i] ? ro_d[32*i +: 32] : reg_q[32*i +: 32];
`ifdef DI_REG_TERMINAL_STATS_EN
        if (di_reg_addr == 32'(NUM_REGS))
            rd_word = stat_wr_cnt;
        if (di_reg_addr == 32'(NUM_REGS + 1))
            rd_word = stat_rd_cnt;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH:  state_nxt = VALID;
            VALID:  if ((di_reg_addr != fetch_addr) || di_read_req || di_read)
                        state_nxt = FETCH;
            COMMIT: state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (wr_acc)
            state_nxt = COMMIT;
    end

    assign di_read_rdy  = (state == VALID);
    assign di_write_rdy = (state != COMMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            fetch_addr         <= 32'd0;
            di_reg_datao       <= 32'd0;
            di_transfer_status <= 16'h0000;
            reg_q              <= {NUM_REGS{RESET_VALUE}};
            wr_strobe          <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                di_reg_datao <= rd_word;
                fetch_addr   <= di_reg_addr;
            end
            // Flags accumulate within a transaction and clear between them
            if (!di_read_mode && !di_write_mode)
                di_transfer_status <= 16'h0000;
            else
                di_transfer_status <= di_transfer_status | stat_new;
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_strobe[i] <= wr_legal && (di_reg_addr == 32'(i));
                if (wr_legal && (di_reg_addr == 32'(i)))
                    reg_q[32*i +: 32] <= di_reg_datai;
            end
        end
    end

endmodule
